rx_buf_malloc_arb: RTL and testbench

//  Shares one RX payload-buffer allocator among NUM_REQ RX pipeline controllers.

---
 rtl/rx_buf_malloc_arb.sv | 118 +++++++++++
 tb/tb_rx_buf_malloc_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_buf_malloc_arb.sv
// rtl/rx_buf_malloc_arb.sv - round-robin malloc request arbiter with in-order response routing
module rx_buf_malloc_arb #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 pipe_malloc_req_val,
  output logic [NUM_REQ-1:0]                 pipe_malloc_req_rdy,
  output logic [NUM_REQ-1:0]                 pipe_malloc_resp_val,
  input  logic [NUM_REQ-1:0]                 pipe_malloc_resp_rdy,
  output logic [ADDR_W-1:0]                  pipe_malloc_resp_addr,
  output logic                               pipe_malloc_resp_ok,
  output logic                               arb_malloc_req_val,
  input  logic                               malloc_arb_req_rdy,
  input  logic                               malloc_arb_resp_val,
  output logic                               arb_malloc_resp_rdy,
  input  logic [ADDR_W-1:0]                  malloc_arb_resp_addr,
  input  logic                               malloc_arb_resp_ok,
  output logic [$clog2(MAX_OUTSTANDING):0]   arb_outstanding,
  output logic                               arb_err_orphan_resp
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic              rst_q;
  logic              active;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   scan_idx;
  logic              found;
  logic [ID_W-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ID_W-1:0]   head;
  logic              empty;
  logic              eligible;
  logic              push;
  logic              route;
  logic              pop;
  logic              orphan;

  // Handshakes stay masked during reset and for one cycle after it.
  assign active = ~rst & ~rst_q;

  always_comb begin
    winner   = rr_ptr;
    found    = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && pipe_malloc_req_val[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  assign empty    = (count == '0);
  assign head     = tag_mem[rd_ptr];
  assign eligible = active & (|pipe_malloc_req_val) & (count < CNT_W'(MAX_OUTSTANDING));
  assign push     = eligible & malloc_arb_req_rdy;
  assign route    = active & ~empty;
  assign pop      = arb_malloc_resp_rdy & malloc_arb_resp_val;
  assign orphan   = active & empty & malloc_arb_resp_val;

  assign arb_malloc_req_val    = eligible;
  assign arb_malloc_resp_rdy   = route & pipe_malloc_resp_rdy[head];
  assign pipe_malloc_resp_addr = malloc_arb_resp_addr;
  assign pipe_malloc_resp_ok   = malloc_arb_resp_ok;
  assign arb_outstanding       = count;

  always_comb begin
    pipe_malloc_req_rdy  = '0;
    pipe_malloc_resp_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pipe_malloc_req_rdy[i]  = push & (winner == ID_W'(i));
      pipe_malloc_resp_val[i] = route & malloc_arb_resp_val & (head == ID_W'(i));
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q               <= 1'b1;
      rr_ptr              <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      arb_err_orphan_resp <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      if (push) begin
        rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (orphan) arb_err_orphan_resp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= winner;
  end

endmodule

// File: tb/tb_rx_buf_malloc_arb.sv
// tb/tb_rx_buf_malloc_arb.sv - directed self-checking bench for rx_buf_malloc_arb
module tb_rx_buf_malloc_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  pipe_malloc_req_val = '0;
  logic [3:0]  pipe_malloc_req_rdy;
  logic [3:0]  pipe_malloc_resp_val;
  logic [3:0]  pipe_malloc_resp_rdy = '0;
  logic [31:0] pipe_malloc_resp_addr;
  logic        pipe_malloc_resp_ok;
  logic        arb_malloc_req_val;
  logic        malloc_arb_req_rdy = 1'b0;
  logic        malloc_arb_resp_val = 1'b0;
  logic        arb_malloc_resp_rdy;
  logic [31:0] malloc_arb_resp_addr = '0;
  logic        malloc_arb_resp_ok = 1'b0;
  logic [2:0]  arb_outstanding;
  logic        arb_err_orphan_resp;

  int n_checks = 0;
  int n_fail   = 0;

  rx_buf_malloc_arb #(.NUM_REQ(4), .ADDR_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .pipe_malloc_req_val   (pipe_malloc_req_val),
    .pipe_malloc_req_rdy   (pipe_malloc_req_rdy),
    .pipe_malloc_resp_val  (pipe_malloc_resp_val),
    .pipe_malloc_resp_rdy  (pipe_malloc_resp_rdy),
    .pipe_malloc_resp_addr (pipe_malloc_resp_addr),
    .pipe_malloc_resp_ok   (pipe_malloc_resp_ok),
    .arb_malloc_req_val    (arb_malloc_req_val),
    .malloc_arb_req_rdy    (malloc_arb_req_rdy),
    .malloc_arb_resp_val   (malloc_arb_resp_val),
    .arb_malloc_resp_rdy   (arb_malloc_resp_rdy),
    .malloc_arb_resp_addr  (malloc_arb_resp_addr),
    .malloc_arb_resp_ok    (malloc_arb_resp_ok),
    .arb_outstanding       (arb_outstanding),
    .arb_err_orphan_resp   (arb_err_orphan_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #4;
  endtask

  task automatic idle_inputs;
    pipe_malloc_req_val  = '0;
    pipe_malloc_resp_rdy = '0;
    malloc_arb_req_rdy   = 1'b0;
    malloc_arb_resp_val  = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [3:0]  t3_req  [3] = '{4'b1000, 4'b0010, 4'b1000};
  logic [31:0] t3_addr [3] = '{32'h0000_A000, 32'h0000_B000, 32'h0000_C000};
  logic        t3_ok   [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    // Reset: outputs masked during rst and the cycle after, even with traffic driven.
    tick();
    pipe_malloc_req_val = 4'hF;
    malloc_arb_req_rdy  = 1'b1;
    settle();
    check("rst_req_rdy", pipe_malloc_req_rdy, 4'h0);
    check("rst_req_val", arb_malloc_req_val, 1'b0);
    check("rst_count", arb_outstanding, 3'd0);
    check("rst_err", arb_err_orphan_resp, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    check("post_rst_req_rdy", pipe_malloc_req_rdy, 4'h0);
    check("post_rst_req_val", arb_malloc_req_val, 1'b0);
    check("post_rst_resp_rdy", arb_malloc_resp_rdy, 1'b0);
    tick();
    idle_inputs();

    // Test 1: single request from requester 2
    pipe_malloc_req_val = 4'b0100;
    malloc_arb_req_rdy  = 1'b1;
    settle();
    check("t1_req_rdy", pipe_malloc_req_rdy, 4'b0100);
    check("t1_req_val", arb_malloc_req_val, 1'b1);
    tick();
    idle_inputs();
    malloc_arb_resp_val  = 1'b1;
    malloc_arb_resp_addr = 32'h0000_1000;
    malloc_arb_resp_ok   = 1'b1;
    pipe_malloc_resp_rdy = 4'b0100;
    settle();
    check("t1_count", arb_outstanding, 3'd1);
    check("t1_resp_val", pipe_malloc_resp_val, 4'b0100);
    check("t1_resp_addr", pipe_malloc_resp_addr, 32'h0000_1000);
    check("t1_resp_ok", pipe_malloc_resp_ok, 1'b1);
    check("t1_resp_rdy", arb_malloc_resp_rdy, 1'b1);
    tick();
    idle_inputs();
    settle();
    check("t1_count_after", arb_outstanding, 3'd0);
    tick();

    // Test 2: fairness from rr_ptr=0, one response popped each cycle
    do_reset();
    for (int k = 0; k < 7; k++) begin
      pipe_malloc_req_val  = 4'hF;
      malloc_arb_req_rdy   = 1'b1;
      pipe_malloc_resp_rdy = 4'hF;
      malloc_arb_resp_val  = (k > 0);
      malloc_arb_resp_addr = 32'h100 * k;
      settle();
      check("t2_grant", pipe_malloc_req_rdy, 4'b0001 << (k % 4));
      if (k > 0) check("t2_route", pipe_malloc_resp_val, 4'b0001 << ((k - 1) % 4));
      tick();
    end
    idle_inputs();
    malloc_arb_resp_val  = 1'b1;
    pipe_malloc_resp_rdy = 4'hF;
    settle();
    check("t2_last_route", pipe_malloc_resp_val, 4'b0100);
    tick();
    idle_inputs();
    settle();
    check("t2_count", arb_outstanding, 3'd0);
    tick();

    // Test 3: ordering 3,1,3 with rr_ptr starting at 3
    for (int k = 0; k < 3; k++) begin
      pipe_malloc_req_val = t3_req[k];
      malloc_arb_req_rdy  = 1'b1;
      settle();
      check("t3_grant", pipe_malloc_req_rdy, t3_req[k]);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      malloc_arb_resp_val  = 1'b1;
      malloc_arb_resp_addr = t3_addr[k];
      malloc_arb_resp_ok   = t3_ok[k];
      pipe_malloc_resp_rdy = 4'hF;
      settle();
      check("t3_count", arb_outstanding, 3'(3 - k));
      check("t3_route", pipe_malloc_resp_val, t3_req[k]);
      check("t3_addr", pipe_malloc_resp_addr, t3_addr[k]);
      check("t3_ok", pipe_malloc_resp_ok, t3_ok[k]);
      tick();
    end
    idle_inputs();
    settle();
    check("t3_count_end", arb_outstanding, 3'd0);
    tick();

    // Test 4: full boundary, requester 0 keeps requesting
    pipe_malloc_req_val = 4'b0001;
    malloc_arb_req_rdy  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("t4_fill_grant", pipe_malloc_req_rdy, 4'b0001);
      tick();
    end
    settle();
    check("t4_full_count", arb_outstanding, 3'd4);
    check("t4_full_req_val", arb_malloc_req_val, 1'b0);
    check("t4_full_req_rdy", pipe_malloc_req_rdy, 4'b0000);
    tick();
    malloc_arb_resp_val  = 1'b1;
    pipe_malloc_resp_rdy = 4'b0001;
    settle();
    check("t4_pop_blocked", arb_malloc_req_val, 1'b0);
    check("t4_pop_route", pipe_malloc_resp_val, 4'b0001);
    tick();
    malloc_arb_resp_val  = 1'b0;
    pipe_malloc_resp_rdy = 4'b0000;
    settle();
    check("t4_after_pop_count", arb_outstanding, 3'd3);
    check("t4_fifth_grant", pipe_malloc_req_rdy, 4'b0001);
    tick();
    idle_inputs();
    malloc_arb_resp_val  = 1'b1;
    pipe_malloc_resp_rdy = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    idle_inputs();
    settle();
    check("t4_drained", arb_outstanding, 3'd0);
    tick();

    // Test 5: backpressure on ID 2 while ID 0 is granted (rr_ptr=1)
    pipe_malloc_req_val = 4'b0100;
    malloc_arb_req_rdy  = 1'b1;
    settle();
    check("t5_grant2", pipe_malloc_req_rdy, 4'b0100);
    tick();
    pipe_malloc_req_val  = 4'b0001;
    malloc_arb_resp_val  = 1'b1;
    malloc_arb_resp_addr = 32'h0000_2222;
    pipe_malloc_resp_rdy = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t5_bp_resp_val", pipe_malloc_resp_val, 4'b0100);
      check("t5_bp_resp_rdy", arb_malloc_resp_rdy, 1'b0);
      if (k == 0) check("t5_grant0", pipe_malloc_req_rdy, 4'b0001);
      tick();
      pipe_malloc_req_val = 4'b0000;
    end
    pipe_malloc_resp_rdy = 4'b0100;
    settle();
    check("t5_count_bp", arb_outstanding, 3'd2);
    check("t5_release", arb_malloc_resp_rdy, 1'b1);
    tick();
    pipe_malloc_resp_rdy = 4'b0001;
    settle();
    check("t5_route0", pipe_malloc_resp_val, 4'b0001);
    tick();
    idle_inputs();
    settle();
    check("t5_count_end", arb_outstanding, 3'd0);
    tick();

    // Test 6: orphan response, then reset mid-flight
    malloc_arb_resp_val  = 1'b1;
    pipe_malloc_resp_rdy = 4'hF;
    settle();
    check("t6_orphan_val", pipe_malloc_resp_val, 4'b0000);
    check("t6_orphan_rdy", arb_malloc_resp_rdy, 1'b0);
    tick();
    idle_inputs();
    settle();
    check("t6_err_set", arb_err_orphan_resp, 1'b1);
    tick();
    pipe_malloc_req_val = 4'hF;
    malloc_arb_req_rdy  = 1'b1;
    settle();
    check("t6_grant1", pipe_malloc_req_rdy, 4'b0010);
    tick();
    settle();
    check("t6_grant2", pipe_malloc_req_rdy, 4'b0100);
    tick();
    idle_inputs();
    settle();
    check("t6_count2", arb_outstanding, 3'd2);
    check("t6_err_sticky", arb_err_orphan_resp, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pipe_malloc_req_val = 4'hF;
    malloc_arb_req_rdy  = 1'b1;
    settle();
    check("t6_rst_count", arb_outstanding, 3'd0);
    check("t6_rst_err", arb_err_orphan_resp, 1'b0);
    check("t6_rst_masked", pipe_malloc_req_rdy, 4'b0000);
    tick();
    settle();
    check("t6_rr_reset", pipe_malloc_req_rdy, 4'b0001);
    tick();
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
